// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seg7 frame scanner: segment map,
// segment bit constants and the scan-counter width function.
package seg7_pkg;

  // a..g active-high, bit0 = a
  localparam logic [6:0] SEG_MAP [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam logic [7:0] SEG_DP  = 8'h80;

  function automatic int unsigned cnt_width(input int unsigned digits,
                                            input int unsigned scan_div);
    return scan_div + $clog2(digits);
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble + decimal point to 8-bit segment pattern,
// active-high; the caller applies pin polarity.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o      = SEG_OFF;
    seg_o[6:0] = SEG_MAP[nibble_i];
    if (dp_i) seg_o = seg_o | SEG_DP;
  end

endmodule

// File: rtl/seg7_frame_scan.sv
// Double-buffered 8-digit 7-segment scanner with anti-ghost blanking and
// tear-free frame swaps. Optional leading-zero suppression: SEG7_ZERO_BLANK_EN.
module seg7_frame_scan
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS         = 8,
  parameter int unsigned SCAN_DIV       = 13,
  parameter int unsigned BLANK_CYC      = 64,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          EN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  input  logic [4*DIGITS-1:0]   frame_data,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [7:0]            dataout,
  output logic [DIGITS-1:0]     en,
  output logic                  scan_tick
);

  localparam int unsigned CW = cnt_width(DIGITS, SCAN_DIV);
  localparam int unsigned SW = CW - SCAN_DIV;
  localparam logic [SCAN_DIV-1:0] BLANK_PH = SCAN_DIV'(BLANK_CYC);
  localparam logic [7:0]          SEG_IDLE = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0]   EN_IDLE  = EN_ACTIVE_LOW ? '1 : '0;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  pending_q, pending_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
  logic [4*DIGITS-1:0]   active_q, active_d;
  logic [DIGITS-1:0]     active_dp_q, active_dp_d;
  logic                  active_valid_q, active_valid_d;
  logic [7:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     en_q, en_d;
  logic                  tick_q, tick_d;

  logic [SW-1:0]         slot;
  logic [SCAN_DIV-1:0]   phase;
  logic [3:0]            nibble;
  logic                  dp;
  logic [7:0]            seg_raw;
  logic [DIGITS-1:0]     lz;
  logic                  blank;
  logic [7:0]            seg_n;
  logic [DIGITS-1:0]     en_n;

  assign slot   = cnt_q[CW-1:SCAN_DIV];
  assign phase  = cnt_q[SCAN_DIV-1:0];
  assign nibble = active_q[{slot, 2'b00} +: 4];
  assign dp     = active_dp_q[slot];

  seg7_hex_decode u_dec (
    .nibble_i (nibble),
    .dp_i     (dp),
    .seg_o    (seg_raw)
  );

  // Swap and accept are mutually exclusive: accept needs !pending, swap needs pending.
  always_comb begin
    cnt_d          = cnt_q + CW'(1);
    pending_d      = pending_q;
    shadow_d       = shadow_q;
    shadow_dp_d    = shadow_dp_q;
    active_d       = active_q;
    active_dp_d    = active_dp_q;
    active_valid_d = active_valid_q;
    tick_d         = (cnt_q == '0);
    if (frame_valid && !pending_q) begin
      shadow_d    = frame_data;
      shadow_dp_d = dp_mask;
      pending_d   = 1'b1;
    end
    if ((cnt_q == '1) && pending_q) begin
      active_d       = shadow_q;
      active_dp_d    = shadow_dp_q;
      active_valid_d = 1'b1;
      pending_d      = 1'b0;
    end
  end

  // Leading-zero flags: set while every digit from the top down to i is zero.
  always_comb begin
    lz = '0;
`ifdef SEG7_ZERO_BLANK_EN
    begin
      logic run;
      run = 1'b1;
      for (int unsigned k = 0; k < DIGITS; k++) begin
        run = run && (active_q[4*(DIGITS-1-k) +: 4] == 4'h0);
        lz[DIGITS-1-k] = run && (k != DIGITS-1);
      end
    end
`endif
  end

  always_comb begin
    blank = !active_valid_q || (phase < BLANK_PH);
    seg_n = SEG_OFF;
    en_n  = '0;
    if (!blank) begin
      if (!lz[slot]) begin
        en_n[slot] = 1'b1;
        seg_n      = seg_raw;
      end else if (dp) begin
        en_n[slot] = 1'b1;
        seg_n      = SEG_DP;
      end
    end
    seg_d = SEG_ACTIVE_LOW ? ~seg_n : seg_n;
    en_d  = EN_ACTIVE_LOW ? ~en_n : en_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      pending_q      <= 1'b0;
      shadow_q       <= '0;
      shadow_dp_q    <= '0;
      active_q       <= '0;
      active_dp_q    <= '0;
      active_valid_q <= 1'b0;
      seg_q          <= SEG_IDLE;
      en_q           <= EN_IDLE;
      tick_q         <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      pending_q      <= pending_d;
      shadow_q       <= shadow_d;
      shadow_dp_q    <= shadow_dp_d;
      active_q       <= active_d;
      active_dp_q    <= active_dp_d;
      active_valid_q <= active_valid_d;
      seg_q          <= seg_d;
      en_q           <= en_d;
      tick_q         <= tick_d;
    end
  end

  assign frame_ready = !pending_q;
  assign dataout     = seg_q;
  assign en          = en_q;
  assign scan_tick   = tick_q;

endmodule

// File: tb/tb_seg7_frame_scan.sv
// Directed bench for seg7_frame_scan with SCAN_DIV=4, BLANK_CYC=2
// (128 cycles per full scan, 16 per digit slot).
module tb_seg7_frame_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_valid;
  logic        frame_ready;
  logic [31:0] frame_data;
  logic [7:0]  dp_mask;
  logic [7:0]  dataout;
  logic [7:0]  en;
  logic        scan_tick;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned last_rdy;

  always #5 clk = ~clk;

  seg7_frame_scan #(
    .DIGITS         (8),
    .SCAN_DIV       (4),
    .BLANK_CYC      (2),
    .SEG_ACTIVE_LOW (1'b1),
    .EN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .dp_mask     (dp_mask),
    .dataout     (dataout),
    .en          (en),
    .scan_tick   (scan_tick)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for scan_tick (bounded); display must stay blank meanwhile.
  task automatic wait_tick(input string tag);
    int unsigned n = 0;
    int unsigned nonblank = 0;
    last_rdy = 0;
    while (!scan_tick && n < 300) begin
      if (en != 8'hFF || dataout != 8'hFF) nonblank++;
      if (frame_ready) last_rdy++;
      step();
      n++;
    end
    chk({tag, "_tick_seen"}, 32'(scan_tick), 32'd1);
    chk({tag, "_blank_before_swap"}, nonblank, 0);
  endtask

  // Called on a scan_tick sample (outputs show slot 0 phase 0); walks one full scan.
  task automatic check_scan(input string tag, input logic [63:0] segx, input logic [63:0] enx);
    for (int k = 0; k < 128; k++) begin
      int s;
      int p;
      s = k / 16;
      p = k % 16;
      if (p < 2) begin
        chk($sformatf("%s_en_s%0d_p%0d", tag, s, p), 32'(en), 32'hFF);
        chk($sformatf("%s_seg_s%0d_p%0d", tag, s, p), 32'(dataout), 32'hFF);
      end else begin
        chk($sformatf("%s_en_s%0d_p%0d", tag, s, p), 32'(en), 32'(enx[8*s +: 8]));
        chk($sformatf("%s_seg_s%0d_p%0d", tag, s, p), 32'(dataout), 32'(segx[8*s +: 8]));
      end
      step();
    end
    chk({tag, "_next_tick"}, 32'(scan_tick), 32'd1);
  endtask

  localparam logic [63:0] EN_ALL = 64'h7FBFDFEFF7FBFDFE;
  localparam logic [63:0] SEG_A  = 64'h30F999F99290A482;
  localparam logic [63:0] SEG_B  = 64'hF9A4B0999282F800;
`ifdef SEG7_ZERO_BLANK_EN
  localparam logic [63:0] SEG_C  = 64'hFFFFFFFFFF9992C0;
  localparam logic [63:0] EN_C   = 64'hFFFFFFFFFFFBFDFE;
`else
  localparam logic [63:0] SEG_C  = 64'hC0C0C0C0C09992C0;
  localparam logic [63:0] EN_C   = EN_ALL;
`endif

  initial begin
    int unsigned ticks;
    int unsigned nonblank;
    int unsigned notrdy;

    rst         = 1'b1;
    frame_valid = 1'b0;
    frame_data  = '0;
    dp_mask     = '0;
    repeat (3) step();
    chk("rst_dataout", 32'(dataout), 32'hFF);
    chk("rst_en", 32'(en), 32'hFF);
    chk("rst_ready", 32'(frame_ready), 32'd1);
    chk("rst_tick", 32'(scan_tick), 32'd0);
    rst = 1'b0;

    ticks = 0;
    nonblank = 0;
    for (int i = 0; i < 128; i++) begin
      step();
      if (scan_tick) ticks++;
      if (en != 8'hFF || dataout != 8'hFF) nonblank++;
    end
    chk("idle_blank", nonblank, 0);
    chk("idle_ticks", ticks, 1);
    repeat (2) step();

    // Frame A accepted, then frame B held under backpressure
    frame_valid = 1'b1;
    frame_data  = 32'h31415926;
    dp_mask     = 8'h80;
    step();
    chk("a_ready_low", 32'(frame_ready), 32'd0);
    frame_data  = 32'h12345678;
    dp_mask     = 8'h01;
    step();
    chk("b_held_ready_low", 32'(frame_ready), 32'd0);
    wait_tick("a");
    chk("b_ready_pulse_cycles", last_rdy, 1);
    chk("b_accepted_after_swap", 32'(frame_ready), 32'd0);
    frame_valid = 1'b0;
    check_scan("a", SEG_A, EN_ALL);
    check_scan("b", SEG_B, EN_ALL);
    chk("b_ready_idle", 32'(frame_ready), 32'd1);

    // Pending frame X then reset at slot 4
    frame_valid = 1'b1;
    frame_data  = 32'h99999999;
    dp_mask     = 8'hFF;
    step();
    frame_valid = 1'b0;
    chk("x_pending", 32'(frame_ready), 32'd0);
    repeat (66) step();
    chk("pre_rst_slot4_en", 32'(en), 32'hEF);
    rst = 1'b1;
    step();
    chk("midrst_dataout", 32'(dataout), 32'hFF);
    chk("midrst_en", 32'(en), 32'hFF);
    chk("midrst_ready", 32'(frame_ready), 32'd1);
    chk("midrst_tick", 32'(scan_tick), 32'd0);
    rst = 1'b0;
    nonblank = 0;
    notrdy = 0;
    for (int i = 0; i < 130; i++) begin
      step();
      if (en != 8'hFF || dataout != 8'hFF) nonblank++;
      if (!frame_ready) notrdy++;
    end
    chk("postrst_blank", nonblank, 0);
    chk("postrst_pending_clear", notrdy, 0);

    // Leading-zero frame
    frame_valid = 1'b1;
    frame_data  = 32'h00000450;
    dp_mask     = 8'h00;
    step();
    frame_valid = 1'b0;
    wait_tick("c");
    check_scan("c", SEG_C, EN_C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_frame_scan.md
Name: seg7_frame_scan

Overview:
Downstream display stage for the pi digit viewer. Accepts complete 8-digit BCD/hex frames from the digit-fetch logic over a valid/ready handshake and double-buffers them. Time-multiplexes the digits onto the shared 7-segment bus with anti-ghosting blanking. Swaps frames only at scan-frame boundaries, so the display never tears.

Parameters:
- DIGITS, 8, number of multiplexed digits; digit 0 is rightmost.
- SCAN_DIV, 13, log2 of clocks per digit slot (8192).
- BLANK_CYC, 64, leading cycles of each slot with all enables off; must be < 2**SCAN_DIV.
- SEG_ACTIVE_LOW, 1, 1 inverts dataout at the pin.
- EN_ACTIVE_LOW, 1, 1 inverts en at the pin.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- frame_valid  in  1  upstream frame available
- frame_ready  out  1  shadow buffer free
- frame_data  in  4*DIGITS  nibble i at [4i+3:4i] = digit i
- dp_mask  in  DIGITS  decimal point per digit, captured with frame_data
- dataout  out  8  segments: bit0=a … bit6=g, bit7=dp
- en  out  DIGITS  digit enables, bit i = digit i
- scan_tick  out  1  one-cycle pulse at start of each full scan

Behaviour:
- Reset (synchronous, active-high) applies to all state. Scan counter cnt (SCAN_DIV+log2(DIGITS) bits) = 0. Shadow pending = 0. Active buffer invalid. dataout and en at inactive level (0xFF with defaults). frame_ready = 1. scan_tick = 0.
- Counter: cnt increments every cycle and wraps freely.
  - slot = cnt[MSB:SCAN_DIV]
  - phase = cnt[SCAN_DIV-1:0]
- Handshake:
  - frame_ready = !pending.
  - On frame_valid && frame_ready, frame_data and dp_mask are captured into the shadow buffer and pending <= 1.
  - Upstream holds data stable while valid && !ready.
- Swap: on the edge where cnt == all-ones and pending == 1:
  - active <= shadow; active_valid <= 1; pending <= 0.
  - frame_ready rises the cycle cnt == 0.
- Accept and boundary in the same cycle: cannot occur with pending set, because ready is low. A frame accepted on the wrap edge while pending == 0 waits for the next boundary.
- Output registers (1-cycle latency from cnt):
  - blank = !active_valid || phase < BLANK_CYC.
  - If blank: en all inactive, dataout all inactive.
  - Otherwise: en = one-hot(slot), and dataout = hexseg(active[slot]) | (dp_mask[slot] << 7). Polarity parameters are applied last.
- Hex segment map (a..g active-high before polarity): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- scan_tick: registered, high for exactly one cycle per 2**(SCAN_DIV+log2 DIGITS) cycles. It is high in the same cycle outputs first reflect slot 0.
- Reset mid-scan: immediate return to reset state. Pending and active frames are discarded, and the display stays blank until a new frame completes a swap.
- Data lingering: the active frame is redisplayed indefinitely if no new frame arrives.

Optional Feature:
- Macro: SEG7_ZERO_BLANK_EN.
- Defined: leading zero nibbles are suppressed. Counting from digit DIGITS-1 downward, each zero digit is blanked (en inactive for that slot) until the first nonzero digit. Digit 0 is always shown. A blanked digit with its dp bit set still shows the dp.
- Undefined: every digit is displayed.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry segment constant array
  - SEG_OFF/SEG_DP bit constants
  - a function computing the counter width from DIGITS
- Sub-module seg7_hex_decode: combinational nibble+dp -> 8-bit segments, polarity-free. The top applies polarity.

Test Plan:
Use SCAN_DIV=4, BLANK_CYC=2 in simulation.
- Reset: assert rst 3 cycles -> dataout=FF, en=FF, frame_ready=1, scan_tick=0. The display stays blank through the first full scan with no frame.
- Load frame_data=31415926, dp_mask=80 -> ready drops next cycle; the display stays blank until the wrap. Then:
  - slot 0 phase≥2: en=FE, dataout=82 ('6').
  - slot 7: en=7F, dataout=30 ('3'+dp).
- Blanking: in every slot, phase 0–1 gives en=FF; phase 2–15 gives exactly one en bit low.
- Backpressure: present a second frame 12345678 while pending -> ready=0, the frame is held. It is accepted on the cycle after the swap, and the old frame remains visible for the full intervening scan (no tearing).
- Mid-scan reset at slot 4 -> next cycle all outputs inactive; pending cleared; the display stays blank until a fresh frame and wrap.
- SEG7_ZERO_BLANK_EN, frame 00000450 -> digits 3–7 en inactive; digit 0 shows C0 ('0'); digits 1,2 show 92 ('5') and 99 ('4'). Without the macro, digit 7 shows C0.
